// File: rtl/serial_to_par3_pkg.sv
// Shared definitions for the serial-to-3-parallel input stage:
// fill-phase encoding and the default sample width.
package serial_to_par3_pkg;

  // Default sample width; matches the downstream FIR data width.
  localparam int unsigned NBIT_DEFAULT = 9;

  // Width of the fill-phase register.
  localparam int unsigned PHASE_W = 2;

  // Number of samples packed into one parallel word.
  localparam int unsigned LANES = 3;

  // Fill phase: number of samples currently held. Encoding 3 is illegal.
  typedef enum logic [PHASE_W-1:0] {
    PH0 = 2'd0,  // empty
    PH1 = 2'd1,  // H0 full
    PH2 = 2'd2   // H0 and H1 full
  } phase_e;

endpackage : serial_to_par3_pkg

// File: rtl/serial_to_par3_reg.sv
// reg_nbit_en: NBIT-wide register with asynchronous active-low clear
// and synchronous load enable.
//   clk   - rising-edge clock
//   rst_n - asynchronous clear, active low
//   en    - load enable; q holds when low
//   d     - data in
//   q     - registered data out
module reg_nbit_en #(
  parameter int unsigned NBIT = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NBIT-1:0] d,
  output logic [NBIT-1:0] q
);

  // Load-enabled storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : reg_nbit_en

// File: rtl/serial_to_par3.sv
// serial_to_par3: packs every three consecutive valid serial samples into
// one parallel word with a single-cycle VOUT strobe. FLUSH closes a partial
// group with zero padding (a sample presented with FLUSH is included first).
//   CLK      - clock, rising edge
//   RST_n    - asynchronous reset, active low
//   DIN      - serial sample, two's complement, passed through bit-exact
//   VIN      - DIN valid this cycle
//   FLUSH    - close the current partial group
//   DOUT3k   - oldest sample of the group (registered, held until next emit)
//   DOUT3k1  - middle sample of the group
//   DOUT3k2  - newest sample of the group
//   VOUT     - one-cycle strobe, parallel word valid
//   PHASE    - current fill phase (0, 1 or 2)
module serial_to_par3
  import serial_to_par3_pkg::*;
#(
  parameter int unsigned NBIT = NBIT_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic [NBIT-1:0]    DIN,
  input  logic               VIN,
  input  logic               FLUSH,
  output logic [NBIT-1:0]    DOUT3k,
  output logic [NBIT-1:0]    DOUT3k1,
  output logic [NBIT-1:0]    DOUT3k2,
  output logic               VOUT,
  output logic [PHASE_W-1:0] PHASE
);

  phase_e phase_q;
  phase_e phase_nxt;

  logic [NBIT-1:0] h0_q;
  logic [NBIT-1:0] h1_q;

  logic            h0_en_c;
  logic            h1_en_c;
  logic            emit_c;
  logic [NBIT-1:0] lane0_c;
  logic [NBIT-1:0] lane1_c;
  logic [NBIT-1:0] lane2_c;

  // Phase state register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      phase_q <= PH0;
    end else begin
      phase_q <= phase_nxt;
    end
  end

  // Next fill phase. Any emit returns to PH0; illegal encoding recovers to PH0.
  always_comb begin
    phase_nxt = phase_q;
    case (phase_q)
      PH0: begin
        if (VIN && !FLUSH) begin
          phase_nxt = PH1;
        end
      end
      PH1: begin
        if (FLUSH) begin
          phase_nxt = PH0;
        end else if (VIN) begin
          phase_nxt = PH2;
        end
      end
      PH2: begin
        if (VIN || FLUSH) begin
          phase_nxt = PH0;
        end
      end
      default: phase_nxt = PH0;
    endcase
  end

  // Holding-register loads, emit decision and the word presented to the
  // output lanes. Padding lanes are forced to zero only on a flush emit.
  always_comb begin
    h0_en_c = 1'b0;
    h1_en_c = 1'b0;
    emit_c  = 1'b0;
    lane0_c = '0;
    lane1_c = '0;
    lane2_c = '0;
    case (phase_q)
      PH0: begin
        if (VIN && FLUSH) begin
          emit_c  = 1'b1;
          lane0_c = DIN;
        end else if (VIN) begin
          h0_en_c = 1'b1;
        end
      end
      PH1: begin
        if (FLUSH) begin
          emit_c  = 1'b1;
          lane0_c = h0_q;
          lane1_c = VIN ? DIN : '0;
        end else if (VIN) begin
          h1_en_c = 1'b1;
        end
      end
      PH2: begin
        if (VIN || FLUSH) begin
          emit_c  = 1'b1;
          lane0_c = h0_q;
          lane1_c = h1_q;
          lane2_c = VIN ? DIN : '0;
        end
      end
      default: begin
        emit_c = 1'b0;
      end
    endcase
  end

  // Strobe register: high for exactly the cycle after an emit decision.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      VOUT <= 1'b0;
    end else begin
      VOUT <= emit_c;
    end
  end

  assign PHASE = phase_q;

  reg_nbit_en #(.NBIT(NBIT)) u_h0 (
    .clk   (CLK),
    .rst_n (RST_n),
    .en    (h0_en_c),
    .d     (DIN),
    .q     (h0_q)
  );

  reg_nbit_en #(.NBIT(NBIT)) u_h1 (
    .clk   (CLK),
    .rst_n (RST_n),
    .en    (h1_en_c),
    .d     (DIN),
    .q     (h1_q)
  );

  reg_nbit_en #(.NBIT(NBIT)) u_out0 (
    .clk   (CLK),
    .rst_n (RST_n),
    .en    (emit_c),
    .d     (lane0_c),
    .q     (DOUT3k)
  );

  reg_nbit_en #(.NBIT(NBIT)) u_out1 (
    .clk   (CLK),
    .rst_n (RST_n),
    .en    (emit_c),
    .d     (lane1_c),
    .q     (DOUT3k1)
  );

  reg_nbit_en #(.NBIT(NBIT)) u_out2 (
    .clk   (CLK),
    .rst_n (RST_n),
    .en    (emit_c),
    .d     (lane2_c),
    .q     (DOUT3k2)
  );

endmodule : serial_to_par3

// File: tb/tb_serial_to_par3.sv
// Bench for serial_to_par3: directed scenarios plus randomized traffic,
// checked against a queue-based packing model.
module tb_serial_to_par3;

  localparam int unsigned NBIT = 9;

  logic            CLK;
  logic            RST_n;
  logic [NBIT-1:0] DIN;
  logic            VIN;
  logic            FLUSH;
  logic [NBIT-1:0] DOUT3k;
  logic [NBIT-1:0] DOUT3k1;
  logic [NBIT-1:0] DOUT3k2;
  logic            VOUT;
  logic [1:0]      PHASE;

  int checks   = 0;
  int failures = 0;

  // Model state: samples accepted but not yet emitted, plus expected outputs.
  logic [NBIT-1:0] pend[$];
  logic [NBIT-1:0] exp_w0;
  logic [NBIT-1:0] exp_w1;
  logic [NBIT-1:0] exp_w2;
  logic            exp_vout;
  int              vout_cnt;

  serial_to_par3 #(.NBIT(NBIT)) dut (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .DIN     (DIN),
    .VIN     (VIN),
    .FLUSH   (FLUSH),
    .DOUT3k  (DOUT3k),
    .DOUT3k1 (DOUT3k1),
    .DOUT3k2 (DOUT3k2),
    .VOUT    (VOUT),
    .PHASE   (PHASE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    exp_w0   = '0;
    exp_w1   = '0;
    exp_w2   = '0;
    exp_vout = 1'b0;
  endtask

  // Accept the sample, then emit when three are held or a flush closes a
  // non-empty group, padding missing samples with zero.
  task automatic model_step(input logic v, input logic f, input logic [NBIT-1:0] d);
    exp_vout = 1'b0;
    if (v) pend.push_back(d);
    if (pend.size() == 3 || (f && pend.size() > 0)) begin
      while (pend.size() < 3) pend.push_back('0);
      exp_w0   = pend[0];
      exp_w1   = pend[1];
      exp_w2   = pend[2];
      exp_vout = 1'b1;
      pend.delete();
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, "_vout"},  16'(VOUT),    16'(exp_vout));
    check_val({tag, "_phase"}, 16'(PHASE),   16'(pend.size()));
    check_val({tag, "_d0"},    16'(DOUT3k),  16'(exp_w0));
    check_val({tag, "_d1"},    16'(DOUT3k1), 16'(exp_w1));
    check_val({tag, "_d2"},    16'(DOUT3k2), 16'(exp_w2));
  endtask

  // One clock with the given inputs; outputs checked 1 time unit after the edge.
  task automatic step(input string tag, input logic v, input logic f, input logic [NBIT-1:0] d);
    VIN   = v;
    FLUSH = f;
    DIN   = d;
    @(posedge CLK);
    model_step(v, f, d);
    #1;
    if (VOUT) vout_cnt++;
    compare_all(tag);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic async_reset(input string tag);
    #2;
    RST_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #1;
    RST_n = 1'b1;
  endtask

  task automatic check_word(input string tag, input logic [NBIT-1:0] a,
                            input logic [NBIT-1:0] b, input logic [NBIT-1:0] c);
    check_val({tag, "_w0"}, 16'(DOUT3k),  16'(a));
    check_val({tag, "_w1"}, 16'(DOUT3k1), 16'(b));
    check_val({tag, "_w2"}, 16'(DOUT3k2), 16'(c));
  endtask

  initial begin
    RST_n = 1'b0;
    DIN   = '0;
    VIN   = 1'b0;
    FLUSH = 1'b0;
    vout_cnt = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    compare_all("reset");
    RST_n = 1'b1;

    // Continuous stream 1..6: strobes on the 3rd and 6th samples.
    for (int i = 1; i <= 6; i++) begin
      step("cont", 1'b1, 1'b0, NBIT'(i));
      check_val("cont_phase_seq", 16'(PHASE), 16'(i % 3));
      if (i == 3) check_word("cont_g0", 9'd1, 9'd2, 9'd3);
      if (i == 6) check_word("cont_g1", 9'd4, 9'd5, 9'd6);
    end
    step("cont_idle", 1'b0, 1'b0, '0);
    check_val("cont_vout_cnt", 16'(vout_cnt), 16'd2);

    // Gapped samples with idle cycles; words hold after the strobe.
    vout_cnt = 0;
    step("gap_a", 1'b1, 1'b0, 9'd10);
    repeat (2) step("gap_i", 1'b0, 1'b0, 9'h155);
    step("gap_b", 1'b1, 1'b0, 9'h1FB);
    repeat (2) step("gap_i", 1'b0, 1'b0, 9'h0AA);
    step("gap_c", 1'b1, 1'b0, 9'd7);
    check_word("gap_word", 9'd10, 9'h1FB, 9'd7);
    repeat (3) step("gap_hold", 1'b0, 1'b0, 9'h033);
    check_word("gap_held", 9'd10, 9'h1FB, 9'd7);
    check_val("gap_vout_cnt", 16'(vout_cnt), 16'd1);

    // Flush of a two-sample group, then flush while empty.
    step("fl_a", 1'b1, 1'b0, 9'd8);
    step("fl_b", 1'b1, 1'b0, 9'd9);
    step("fl_go", 1'b0, 1'b1, '0);
    check_val("fl_vout", 16'(VOUT), 16'd1);
    check_word("fl_word", 9'd8, 9'd9, 9'd0);
    step("fl_empty", 1'b0, 1'b1, '0);
    check_val("fl_empty_vout", 16'(VOUT), 16'd0);

    // Flush together with the first sample.
    step("fv", 1'b1, 1'b1, 9'h0FF);
    check_word("fv_word", 9'h0FF, 9'd0, 9'd0);
    step("fv_next", 1'b0, 1'b0, '0);
    check_val("fv_phase", 16'(PHASE), 16'd0);

    // Reset mid-group discards the partial samples.
    step("rst_a", 1'b1, 1'b0, 9'd1);
    step("rst_b", 1'b1, 1'b0, 9'd2);
    async_reset("rst_mid");
    step("rst_c", 1'b1, 1'b0, 9'd3);
    step("rst_d", 1'b1, 1'b0, 9'd4);
    step("rst_e", 1'b1, 1'b0, 9'd5);
    check_word("rst_word", 9'd3, 9'd4, 9'd5);

    // Extreme values pass through bit-exact.
    step("ext_a", 1'b1, 1'b0, 9'h100);
    step("ext_b", 1'b1, 1'b0, 9'h0FF);
    step("ext_c", 1'b1, 1'b0, 9'h1FF);
    check_word("ext_word", 9'h100, 9'h0FF, 9'h1FF);

    // Randomized traffic with occasional flushes and resets.
    for (int n = 0; n < 600; n++) begin
      logic v;
      logic f;
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 9) == 0);
      step("rnd", v, f, NBIT'($urandom));
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_to_par3
